// File: rtl/alu_issue_pkg.sv
// Shared RV32I ALU issue definitions: opcode/funct constants, control IDs,
// the buffered entry layout and the skid-buffer state encoding.
package alu_issue_pkg;

    localparam logic [6:0] OPC_OP    = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI   = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC = 7'b0010111;

    localparam logic [2:0] FUNCT3_ADD  = 3'b000;
    localparam logic [2:0] FUNCT3_SLL  = 3'b001;
    localparam logic [2:0] FUNCT3_SLT  = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU = 3'b011;
    localparam logic [2:0] FUNCT3_XOR  = 3'b100;
    localparam logic [2:0] FUNCT3_SR   = 3'b101;
    localparam logic [2:0] FUNCT3_OR   = 3'b110;
    localparam logic [2:0] FUNCT3_AND  = 3'b111;

    localparam logic [6:0] FUNCT7_BASE = 7'b0000000;
    localparam logic [6:0] FUNCT7_ALT  = 7'b0100000;

    localparam logic [9:0] CID_ADD  = {FUNCT3_ADD,  FUNCT7_BASE};
    localparam logic [9:0] CID_SUB  = {FUNCT3_ADD,  FUNCT7_ALT};
    localparam logic [9:0] CID_SLL  = {FUNCT3_SLL,  FUNCT7_BASE};
    localparam logic [9:0] CID_SLT  = {FUNCT3_SLT,  FUNCT7_BASE};
    localparam logic [9:0] CID_SLTU = {FUNCT3_SLTU, FUNCT7_BASE};
    localparam logic [9:0] CID_XOR  = {FUNCT3_XOR,  FUNCT7_BASE};
    localparam logic [9:0] CID_SRL  = {FUNCT3_SR,   FUNCT7_BASE};
    localparam logic [9:0] CID_SRA  = {FUNCT3_SR,   FUNCT7_ALT};
    localparam logic [9:0] CID_OR   = {FUNCT3_OR,   FUNCT7_BASE};
    localparam logic [9:0] CID_AND  = {FUNCT3_AND,  FUNCT7_BASE};

    typedef struct packed {
        logic [9:0]  cid;
        logic [31:0] arg1;
        logic [31:0] arg2;
        logic [4:0]  rd;
        logic        illegal;
    } issue_t;

    typedef enum logic [1:0] {
        BUF_EMPTY = 2'd0,
        BUF_ONE   = 2'd1,
        BUF_FULL  = 2'd2
    } buf_state_t;

    function automatic logic is_shift(input logic [2:0] funct3);
        return (funct3 == FUNCT3_SLL) || (funct3 == FUNCT3_SR);
    endfunction

endpackage

// File: rtl/alu_issue_dec.sv
// Combinational RV32I OP/OP-IMM/LUI/AUIPC decoder producing one ALU issue entry.
module alu_issue_dec
    import alu_issue_pkg::*;
#(
    parameter logic [9:0] ILLEGAL_CID = 10'h3FF,
    parameter bit         EN_UPPER    = 1'b1
) (
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic [31:0] rs1,
    input  logic [31:0] rs2,
    output issue_t      dec
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        legal;
    logic [9:0]  cid;
    logic [31:0] arg1;
    logic [31:0] arg2;

    assign opcode = instr[6:0];
    assign funct3 = instr[14:12];
    assign funct7 = instr[31:25];

    always_comb begin
        legal = 1'b0;
        cid   = ILLEGAL_CID;
        arg1  = '0;
        arg2  = '0;
        unique case (opcode)
            OPC_OP: begin
                legal = (funct7 == FUNCT7_BASE) ||
                        ((funct7 == FUNCT7_ALT) &&
                         ((funct3 == FUNCT3_ADD) || (funct3 == FUNCT3_SR)));
                cid   = {funct3, funct7};
                arg1  = rs1;
                // The ALU shifts by the full arg2, so the amount is masked here.
                arg2  = is_shift(funct3) ? {27'b0, rs2[4:0]} : rs2;
            end
            OPC_OPIMM: begin
                arg1 = rs1;
                if (is_shift(funct3)) begin
                    legal = (funct7 == FUNCT7_BASE) ||
                            ((funct3 == FUNCT3_SR) && (funct7 == FUNCT7_ALT));
                    cid   = {funct3, funct7};
                    arg2  = {27'b0, instr[24:20]};
                end else begin
                    // instr[30] is immediate bits here, so ADDI never maps to SUB.
                    legal = 1'b1;
                    cid   = {funct3, FUNCT7_BASE};
                    arg2  = {{20{instr[31]}}, instr[31:20]};
                end
            end
            OPC_LUI: begin
                legal = EN_UPPER;
                cid   = CID_ADD;
                arg1  = '0;
                arg2  = {instr[31:12], 12'b0};
            end
            OPC_AUIPC: begin
                legal = EN_UPPER;
                cid   = CID_ADD;
                arg1  = pc;
                arg2  = {instr[31:12], 12'b0};
            end
            default: legal = 1'b0;
        endcase
    end

    always_comb begin
        if (legal) begin
            dec.cid     = cid;
            dec.arg1    = arg1;
            dec.arg2    = arg2;
            dec.rd      = instr[11:7];
            dec.illegal = 1'b0;
        end else begin
            dec.cid     = ILLEGAL_CID;
            dec.arg1    = '0;
            dec.arg2    = '0;
            dec.rd      = '0;
            dec.illegal = 1'b1;
        end
    end

endmodule

// File: rtl/alu_issue.sv
// ALU issue stage: decodes accepted words into a 2-entry skid buffer whose
// head drives the ALU operation interface.
module alu_issue
    import alu_issue_pkg::*;
#(
    parameter logic [9:0] ILLEGAL_CID = 10'h3FF,
    parameter bit         EN_UPPER    = 1'b1
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        iss_valid_in,
    output logic        iss_ready_out,
    input  logic [31:0] iss_instr_in,
    input  logic [31:0] iss_pc_in,
    input  logic [31:0] iss_rs1_in,
    input  logic [31:0] iss_rs2_in,
    output logic        alu_valid_out,
    input  logic        alu_ready_in,
    output logic [9:0]  alu_cid_out,
    output logic [31:0] alu_arg1_out,
    output logic [31:0] alu_arg2_out,
    output logic [4:0]  alu_rd_out,
    output logic        alu_illegal_out
);

    localparam issue_t RESET_ENTRY = '{
        cid:     ILLEGAL_CID,
        arg1:    32'd0,
        arg2:    32'd0,
        rd:      5'd0,
        illegal: 1'b0
    };

    buf_state_t state;
    buf_state_t state_nxt;
    issue_t     dec;
    issue_t     head;
    issue_t     tail;
    logic       ready;
    logic       accept;
    logic       pop;
    logic       head_from_dec;
    logic       head_from_tail;
    logic       tail_from_dec;

    alu_issue_dec #(
        .ILLEGAL_CID (ILLEGAL_CID),
        .EN_UPPER    (EN_UPPER)
    ) u_dec (
        .instr (iss_instr_in),
        .pc    (iss_pc_in),
        .rs1   (iss_rs1_in),
        .rs2   (iss_rs2_in),
        .dec   (dec)
    );

    assign accept = iss_valid_in && ready;
    assign pop    = (state != BUF_EMPTY) && alu_ready_in;

    always_comb begin
        state_nxt      = state;
        head_from_dec  = 1'b0;
        head_from_tail = 1'b0;
        tail_from_dec  = 1'b0;
        unique case (state)
            BUF_EMPTY: begin
                if (accept) begin
                    state_nxt     = BUF_ONE;
                    head_from_dec = 1'b1;
                end
            end
            BUF_ONE: begin
                if (accept && pop) begin
                    head_from_dec = 1'b1;
                end else if (accept) begin
                    state_nxt     = BUF_FULL;
                    tail_from_dec = 1'b1;
                end else if (pop) begin
                    state_nxt = BUF_EMPTY;
                end
            end
            BUF_FULL: begin
                if (pop) begin
                    state_nxt      = BUF_ONE;
                    head_from_tail = 1'b1;
                end
            end
            default: state_nxt = BUF_EMPTY;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state <= BUF_EMPTY;
            ready <= 1'b1;
            head  <= RESET_ENTRY;
            tail  <= RESET_ENTRY;
        end else begin
            state <= state_nxt;
            ready <= (state_nxt != BUF_FULL);
            if (head_from_dec) begin
                head <= dec;
            end else if (head_from_tail) begin
                head <= tail;
            end
            if (tail_from_dec) begin
                tail <= dec;
            end
        end
    end

    assign iss_ready_out   = ready;
    assign alu_valid_out   = (state != BUF_EMPTY);
    assign alu_cid_out     = head.cid;
    assign alu_arg1_out    = head.arg1;
    assign alu_arg2_out    = head.arg2;
    assign alu_rd_out      = head.rd;
    assign alu_illegal_out = head.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode/backpressure/reset cases plus random
// traffic against a queue-based reference model.
module tb_alu_issue;

    typedef struct {
        logic [9:0]  cid;
        logic [31:0] arg1;
        logic [31:0] arg2;
        logic [4:0]  rd;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        iss_valid = 1'b0;
    logic        iss_ready;
    logic [31:0] iss_instr = '0;
    logic [31:0] iss_pc = '0;
    logic [31:0] iss_rs1 = '0;
    logic [31:0] iss_rs2 = '0;
    logic        alu_valid;
    logic        alu_ready = 1'b0;
    logic [9:0]  alu_cid;
    logic [31:0] alu_arg1;
    logic [31:0] alu_arg2;
    logic [4:0]  alu_rd;
    logic        alu_illegal;

    int unsigned tests = 0;
    int unsigned errors = 0;
    exp_t        q[$];

    alu_issue #(
        .ILLEGAL_CID (10'h3FF),
        .EN_UPPER    (1'b1)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst),
        .iss_valid_in    (iss_valid),
        .iss_ready_out   (iss_ready),
        .iss_instr_in    (iss_instr),
        .iss_pc_in       (iss_pc),
        .iss_rs1_in      (iss_rs1),
        .iss_rs2_in      (iss_rs2),
        .alu_valid_out   (alu_valid),
        .alu_ready_in    (alu_ready),
        .alu_cid_out     (alu_cid),
        .alu_arg1_out    (alu_arg1),
        .alu_arg2_out    (alu_arg2),
        .alu_rd_out      (alu_rd),
        .alu_illegal_out (alu_illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference decode straight from the ISA tables: which words are legal ALU ops
    // and what operands they carry.
    function automatic exp_t ref_decode(input logic [31:0] w, input logic [31:0] pc,
                                        input logic [31:0] r1, input logic [31:0] r2);
        exp_t e;
        int   f3 = int'(w[14:12]);
        int   f7 = int'(w[31:25]);
        bit   shift = (f3 == 1) || (f3 == 5);
        bit   ok = 1'b0;
        e = '{cid: 10'h3FF, arg1: 0, arg2: 0, rd: 0, illegal: 1'b1};
        case (w[6:0])
            7'h33: begin
                ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5));
                e.cid = 10'(f3 * 128 + f7);
                e.arg1 = r1;
                e.arg2 = shift ? r2 % 32 : r2;
            end
            7'h13: begin
                e.arg1 = r1;
                if (f3 == 1) ok = (f7 == 0);
                else if (f3 == 5) ok = (f7 == 0) || (f7 == 32);
                else ok = 1'b1;
                e.cid = shift ? 10'(f3 * 128 + f7) : 10'(f3 * 128);
                e.arg2 = shift ? (w >> 20) % 32 : 32'($signed(w) >>> 20);
            end
            7'h37: begin
                ok = 1'b1;
                e.cid = 10'h000;
                e.arg1 = 0;
                e.arg2 = w & 32'hFFFF_F000;
            end
            7'h17: begin
                ok = 1'b1;
                e.cid = 10'h000;
                e.arg1 = pc;
                e.arg2 = w & 32'hFFFF_F000;
            end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            e.rd = w[11:7];
            e.illegal = 1'b0;
        end else begin
            e = '{cid: 10'h3FF, arg1: 0, arg2: 0, rd: 0, illegal: 1'b1};
        end
        return e;
    endfunction

    task automatic compare_model();
        check("valid", 32'(alu_valid), 32'(q.size() > 0));
        check("ready", 32'(iss_ready), 32'(q.size() < 2));
        if (q.size() > 0) begin
            check("cid", 32'(alu_cid), 32'(q[0].cid));
            check("arg1", alu_arg1, q[0].arg1);
            check("arg2", alu_arg2, q[0].arg2);
            check("rd", 32'(alu_rd), 32'(q[0].rd));
            check("illegal", 32'(alu_illegal), 32'(q[0].illegal));
        end
    endtask

    // Called at a negedge: check outputs, drive one cycle, advance the model.
    task automatic step(input bit v, input logic [31:0] w, input logic [31:0] pc,
                        input logic [31:0] r1, input logic [31:0] r2, input bit rdy);
        bit acc;
        bit pop;
        compare_model();
        iss_valid = v;
        iss_instr = w;
        iss_pc    = pc;
        iss_rs1   = r1;
        iss_rs2   = r2;
        alu_ready = rdy;
        acc = v && (q.size() < 2);
        pop = (q.size() > 0) && rdy;
        @(posedge clk);
        if (pop) void'(q.pop_front());
        if (acc) q.push_back(ref_decode(w, pc, r1, r2));
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom();
        int          sel = $urandom_range(0, 9);
        int          f7sel = $urandom_range(0, 3);
        if (sel <= 3) w[6:0] = 7'h33;
        else if (sel <= 6) w[6:0] = 7'h13;
        else if (sel == 7) w[6:0] = 7'h37;
        else if (sel == 8) w[6:0] = 7'h17;
        if (sel <= 6 && f7sel == 0) w[31:25] = 7'h00;
        else if (sel <= 6 && f7sel == 1) w[31:25] = 7'h20;
        return w;
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst_valid", 32'(alu_valid), 32'd0);
        check("rst_ready", 32'(iss_ready), 32'd1);
        check("rst_cid", 32'(alu_cid), 32'h3FF);
        check("rst_arg1", alu_arg1, 32'd0);
        check("rst_arg2", alu_arg2, 32'd0);
        check("rst_rd", 32'(alu_rd), 32'd0);
        check("rst_illegal", 32'(alu_illegal), 32'd0);

        step(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7, 1'b1);
        check("add_valid", 32'(alu_valid), 32'd1);
        check("add_cid", 32'(alu_cid), 32'h000);
        check("add_arg1", alu_arg1, 32'd5);
        check("add_arg2", alu_arg2, 32'd7);
        check("add_rd", 32'(alu_rd), 32'd3);
        check("add_illegal", 32'(alu_illegal), 32'd0);
        step(1'b1, 32'h402081B3, 32'h0, 32'd5, 32'd7, 1'b1);
        check("sub_cid", 32'(alu_cid), 32'h020);
        step(1'b1, 32'h40335293, 32'h0, 32'h8000_0000, 32'd0, 1'b1);
        check("srai_cid", 32'(alu_cid), 32'h2A0);
        check("srai_arg2", alu_arg2, 32'd3);
        check("srai_rd", 32'(alu_rd), 32'd5);
        step(1'b1, 32'h002091B3, 32'h0, 32'd1, 32'h25, 1'b1);
        check("sll_arg2", alu_arg2, 32'd5);
        step(1'b1, 32'hFFF00093, 32'h0, 32'd0, 32'd0, 1'b1);
        check("addi_cid", 32'(alu_cid), 32'h000);
        check("addi_arg2", alu_arg2, 32'hFFFF_FFFF);
        step(1'b1, 32'h123450B7, 32'h0, 32'd9, 32'd9, 1'b1);
        check("lui_arg1", alu_arg1, 32'd0);
        check("lui_arg2", alu_arg2, 32'h1234_5000);
        step(1'b1, 32'h12345097, 32'h100, 32'd9, 32'd9, 1'b1);
        check("auipc_arg1", alu_arg1, 32'h100);
        step(1'b1, 32'h0000_0000, 32'h0, 32'd9, 32'd9, 1'b1);
        check("ill_valid", 32'(alu_valid), 32'd1);
        check("ill_flag", 32'(alu_illegal), 32'd1);
        check("ill_cid", 32'(alu_cid), 32'h3FF);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);
        check("drain_valid", 32'(alu_valid), 32'd0);

        // Backpressure: three back-to-back ADDs tagged by rs1 = 11, 22, 33.
        step(1'b1, 32'h002081B3, 32'h0, 32'd11, 32'd1, 1'b0);
        check("bp_ready1", 32'(iss_ready), 32'd1);
        step(1'b1, 32'h002081B3, 32'h0, 32'd22, 32'd1, 1'b0);
        check("bp_ready2", 32'(iss_ready), 32'd0);
        step(1'b1, 32'h002081B3, 32'h0, 32'd33, 32'd1, 1'b0);
        check("bp_hold_ready", 32'(iss_ready), 32'd0);
        check("bp_hold_head", alu_arg1, 32'd11);
        step(1'b1, 32'h002081B3, 32'h0, 32'd33, 32'd1, 1'b0);
        check("bp_hold_head2", alu_arg1, 32'd11);
        step(1'b1, 32'h002081B3, 32'h0, 32'd33, 32'd1, 1'b1);
        check("bp_drain2", alu_arg1, 32'd22);
        step(1'b1, 32'h002081B3, 32'h0, 32'd33, 32'd1, 1'b1);
        check("bp_drain3", alu_arg1, 32'd33);
        step(1'b0, 32'h0, 32'h0, 32'd0, 32'd0, 1'b1);
        check("bp_empty", 32'(alu_valid), 32'd0);

        // Reset while FULL discards both entries.
        step(1'b1, 32'h002081B3, 32'h0, 32'd44, 32'd1, 1'b0);
        step(1'b1, 32'h002081B3, 32'h0, 32'd55, 32'd1, 1'b0);
        check("full_ready", 32'(iss_ready), 32'd0);
        iss_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        q.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rstfull_valid", 32'(alu_valid), 32'd0);
        check("rstfull_ready", 32'(iss_ready), 32'd1);
        check("rstfull_cid", 32'(alu_cid), 32'h3FF);

        for (int i = 0; i < 2000; i++) begin
            step(($urandom() % 4) != 0, rand_instr(), $urandom(), $urandom(), $urandom(),
                 ($urandom() % 3) != 0);
        end
        compare_model();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage on the producer side of the ALU operation interface.
- Decodes RV32I OP, OP-IMM, LUI and AUIPC instruction words, together with the register-file operands and PC supplied with each word.
- Produces the registered ALU control ID {funct3, funct7}, both ALU arguments, the destination register and an illegal flag.
- A 2-entry skid buffer with valid/ready handshakes on both sides decouples the fetch side from ALU/writeback backpressure.

Parameters:
- ILLEGAL_CID, 10'h3FF, control ID driven when the instruction is not a legal ALU op.
- EN_UPPER, 1, 1 decodes LUI/AUIPC as ADD ops; 0 flags them illegal.

Ports:
- clk_in  input  1  system clock, rising edge.
- rst_in  input  1  reset, synchronous, active-high.
- iss_valid_in  input  1  instruction word and operands valid.
- iss_ready_out  output  1  stage can accept this cycle.
- iss_instr_in  input  32  instruction word.
- iss_pc_in  input  32  PC of the instruction.
- iss_rs1_in  input  32  rs1 register value.
- iss_rs2_in  input  32  rs2 register value.
- alu_valid_out  output  1  head entry valid.
- alu_ready_in  input  1  downstream consumes the head entry.
- alu_cid_out  output  10  {funct3[9:7], funct7[6:0]}.
- alu_arg1_out  output  32  first ALU operand.
- alu_arg2_out  output  32  second ALU operand.
- alu_rd_out  output  5  destination register.
- alu_illegal_out  output  1  head entry is illegal (qualified by alu_valid_out).

Behaviour:
- Reset (rst_in=1 at clock edge): count=0, alu_valid_out=0, iss_ready_out=1. alu_cid_out=ILLEGAL_CID, args=0, rd=0, illegal=0. Reset mid-operation discards buffered entries.
- Handshakes:
  - Accept occurs when iss_valid_in && iss_ready_out.
  - Pop occurs when alu_valid_out && alu_ready_in.
  - Payload on alu_* is stable while alu_valid_out=1 and no pop has occurred.
- Buffer states:
  - EMPTY: accept -> ONE.
  - ONE: accept without pop -> FULL; pop without accept -> EMPTY; both -> ONE, new entry becomes head.
  - FULL: pop -> ONE; no accept is possible in FULL.
- iss_ready_out is registered and equals (state != FULL).
- Latency: 1 cycle from accept to alu_valid_out when the buffer is empty. Throughput is 1 op/cycle while alu_ready_in=1. Order is strictly FIFO.
- Decode, on the accepted word; the opcode field is instr[6:0]:
  - OP 0110011: cid={f3,f7}. Legal f7 is 0000000 for all f3; 0100000 only for f3 000 and 101. arg1=rs1. arg2=rs2 for non-shifts; for shifts (f3 001/101), arg2={27'b0, rs2[4:0]}.
  - OP-IMM 0010011:
    - arg1=rs1.
    - Non-shifts: cid={f3,7'b0}; arg2=sign-extended instr[31:20]. f3=000 with instr[30] set is ADDI, never SUB.
    - SLLI: instr[31:25] must be 0.
    - SRLI/SRAI: instr[31:25] is 0000000 or 0100000.
    - Shifts: cid={f3, instr[31:25]}; arg2={27'b0, instr[24:20]}.
  - LUI 0110111: cid={000,0000000}, arg1=0, arg2={instr[31:12],12'b0}.
  - AUIPC 0010111: cid={000,0000000}, arg1=pc, arg2={instr[31:12],12'b0}.
  - rd=instr[11:7] for all legal ops.
  - Anything else: illegal=1, cid=ILLEGAL_CID, args=0, rd=0. The entry is still buffered and popped normally.
- Shift masking is mandatory: the ALU shifts by the full 32-bit arg2.
- rd=0 ops are issued normally; discarding the result is writeback's job.

Decomposition:
- Shared package/header (extends define.vh):
  - opcode constants OPC_OP, OPC_OPIMM, OPC_LUI, OPC_AUIPC;
  - the FUNCT3_*/FUNCT7_* constants;
  - CID_* localparams built as {funct3, funct7}.
- Sub-module alu_issue_dec: purely combinational instruction -> {cid, arg1, arg2, rd, illegal}. The top holds the 2-entry buffer and state.

Test Plan:
- ADD x3,x1,x2 (0x002081B3), rs1=5, rs2=7, ready=1 -> next cycle: valid=1, cid=10'h000, arg1=5, arg2=7, rd=3, illegal=0.
- SUB 0x402081B3 -> cid=10'h020. SRAI x5,x6,3 (0x40335293), rs1=0x80000000 -> cid=10'h2A0, arg2=3, rd=5.
- SLL with rs2=0x25 -> arg2=5. ADDI x1,x0,-1 (0xFFF00093) -> cid=10'h000, arg2=0xFFFFFFFF.
- LUI x1,0x12345 (0x123450B7) -> arg1=0, arg2=0x12345000. AUIPC with pc=0x100 -> arg1=0x100.
- Backpressure:
  - Stimulus: alu_ready_in=0 for 4 cycles while offering 3 back-to-back ops.
  - Required: ops 1-2 accepted; iss_ready_out=0 from the cycle after the 2nd accept; op 3 held.
  - Required on release: outputs drain 1,2,3 in order at 1/cycle.
- Illegal word 0x00000000 -> valid=1, illegal=1, cid=10'h3FF. Reset asserted while FULL -> next cycle valid=0, ready=1.
